// File: rtl/gray_counter.sv
// Up/down binary counter that presents its count in binary and Gray form,
// plus an independent registered Gray-to-binary decoder.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             at_limit,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_in_vld,
    output logic [WIDTH-1:0] dec_bin,
    output logic             dec_vld
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] dec_bin_q, dec_bin_d;
    logic             dec_vld_q, dec_vld_d;
    logic [WIDTH-1:0] dec_calc;

    // Next count: load beats en; at either end WRAP chooses wrap-around or hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX_VAL) begin
                    if (WRAP) begin
                        bin_d  = MIN_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == MIN_VAL) begin
                    if (WRAP) begin
                        bin_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
    end

    // Gray code is derived from the next binary value so both registers stay in step.
    always_comb begin
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Each binary bit is the XOR of all Gray bits at or above it; written as
    // independent reductions so synthesis can build balanced trees.
    always_comb begin
        dec_calc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_calc[i] = ^(gray_in >> i);
        end
    end

    // gray_in_vld qualifies gray_in; there is no ready, one decode is accepted every cycle.
    always_comb begin
        dec_bin_d = dec_bin_q;
        dec_vld_d = 1'b0;
        if (gray_in_vld) begin
            dec_bin_d = dec_calc;
            dec_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            gray_q    <= '0;
            wrap_q    <= 1'b0;
            dec_bin_q <= '0;
            dec_vld_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrap_q    <= wrap_d;
            dec_bin_q <= dec_bin_d;
            dec_vld_q <= dec_vld_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign at_limit = up ? (bin_q == MAX_VAL) : (bin_q == MIN_VAL);
    assign dec_bin  = dec_bin_q;
    assign dec_vld  = dec_vld_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (4-bit wrapping, 4-bit saturating,
// 8-bit wrapping) share stimulus and are checked against an integer model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, gv;
    logic [3:0] lb4, gi4;
    logic [7:0] lb8, gi8;

    logic [3:0] b4, g4, db4, bs, gs, dbs;
    logic [7:0] b8, g8, db8;
    logic       w4, al4, dv4, ws, als, dvs, w8, al8, dv8;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m4, ms, m8, md4, md8;
    bit mw4, mws, mw8, mdv;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb4),
        .bin_out(b4), .gray_out(g4), .wrap(w4), .at_limit(al4),
        .gray_in(gi4), .gray_in_vld(gv), .dec_bin(db4), .dec_vld(dv4));

    gray_counter #(.WIDTH(4), .WRAP(1'b0)) us (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb4),
        .bin_out(bs), .gray_out(gs), .wrap(ws), .at_limit(als),
        .gray_in(gi4), .gray_in_vld(gv), .dec_bin(dbs), .dec_vld(dvs));

    gray_counter #(.WIDTH(8), .WRAP(1'b1)) u8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb8),
        .bin_out(b8), .gray_out(g8), .wrap(w8), .at_limit(al8),
        .gray_in(gi8), .gray_in_vld(gv), .dec_bin(db8), .dec_vld(dv8));

    function automatic int gray_of(int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by searching for the value whose Gray code matches.
    function automatic int g2b(int g, int w);
        for (int v = 0; v < (1 << w); v++)
            if (gray_of(v) == g) return v;
        return -1;
    endfunction

    function automatic int popcount(int x);
        int n = 0;
        for (int i = 0; i < 32; i++) n += (x >> i) & 1;
        return n;
    endfunction

    task automatic adv(inout int c, inout bit w, input int maxv, input bit wrapm);
        w = 1'b0;
        if (up) begin
            if (c == maxv) begin
                if (wrapm) begin c = 0; w = 1'b1; end
            end else c = c + 1;
        end else begin
            if (c == 0) begin
                if (wrapm) begin c = maxv; w = 1'b1; end
            end else c = c - 1;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m4 = 0; ms = 0; m8 = 0; mw4 = 0; mws = 0; mw8 = 0;
            md4 = 0; md8 = 0; mdv = 0;
        end else begin
            if (load) begin
                m4 = lb4; ms = lb4; m8 = lb8; mw4 = 0; mws = 0; mw8 = 0;
            end else if (en) begin
                adv(m4, mw4, 15, 1'b1);
                adv(ms, mws, 15, 1'b0);
                adv(m8, mw8, 255, 1'b1);
            end else begin
                mw4 = 0; mws = 0; mw8 = 0;
            end
            if (gv) begin
                md4 = g2b(gi4, 4); md8 = g2b(gi8, 8); mdv = 1;
            end else mdv = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; load = 0; en = 0; gv = 0;
    endtask

    task automatic test_reset();
        rst = 1; load = 1; en = 1; up = 1; lb4 = 4'h5; lb8 = 8'h5A; gv = 1; gi4 = 4'h3; gi8 = 8'h3;
        tick();
        checks++; if (b4 !== 4'h0) begin errors++; $display("FAIL reset_bin: got %h expected 0", b4); end
        checks++; if (g4 !== 4'h0) begin errors++; $display("FAIL reset_gray: got %h expected 0", g4); end
        checks++; if (w4 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", w4); end
        checks++; if (db4 !== 4'h0 || dv4 !== 1'b0) begin errors++; $display("FAIL reset_dec: got %h/%b expected 0/0", db4, dv4); end
        checks++; if (b8 !== 8'h0 || bs !== 4'h0) begin errors++; $display("FAIL reset_others: got %h/%h expected 0/0", b8, bs); end
        checks++; if (al4 !== 1'b0) begin errors++; $display("FAIL reset_at_limit_up: got %b expected 0", al4); end
        up = 0; #1;
        checks++; if (al4 !== 1'b1) begin errors++; $display("FAIL reset_at_limit_dn: got %b expected 1", al4); end
        idle();
    endtask

    task automatic test_load_step();
        load = 1; lb4 = 4'b0111; tick(); load = 0;
        checks++; if (b4 !== 4'b0111 || g4 !== 4'b0100) begin errors++; $display("FAIL load: got %b/%b expected 0111/0100", b4, g4); end
        en = 1; up = 1; tick(); en = 0;
        checks++; if (b4 !== 4'b1000 || g4 !== 4'b1100) begin errors++; $display("FAIL step_up: got %b/%b expected 1000/1100", b4, g4); end
    endtask

    task automatic test_up_wrap();
        load = 1; lb4 = 4'b1111; up = 1; tick(); load = 0;
        checks++; if (al4 !== 1'b1 || g4 !== 4'b1000) begin errors++; $display("FAIL up_wrap_pre: got al=%b g=%b expected 1/1000", al4, g4); end
        en = 1; tick(); en = 0;
        checks++; if (b4 !== 4'b0000 || g4 !== 4'b0000 || w4 !== 1'b1) begin errors++; $display("FAIL up_wrap: got %b/%b/%b expected 0000/0000/1", b4, g4, w4); end
        tick();
        checks++; if (w4 !== 1'b0) begin errors++; $display("FAIL up_wrap_pulse: got %b expected 0", w4); end
    endtask

    task automatic test_down_wrap();
        rst = 1; tick(); rst = 0;
        en = 1; up = 0; tick(); en = 0;
        checks++; if (b4 !== 4'b1111 || g4 !== 4'b1000 || w4 !== 1'b1) begin errors++; $display("FAIL down_wrap: got %b/%b/%b expected 1111/1000/1", b4, g4, w4); end
        tick();
        checks++; if (w4 !== 1'b0 || b4 !== 4'b1111) begin errors++; $display("FAIL down_wrap_hold: got %b/%b expected 1111/0", b4, w4); end
    endtask

    task automatic test_saturate();
        load = 1; lb4 = 4'b1111; tick(); load = 0;
        en = 1; up = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bs !== 4'b1111 || ws !== 1'b0 || gs !== 4'b1000) begin errors++; $display("FAIL sat_up%0d: got %b/%b/%b expected 1111/1000/0", i, bs, gs, ws); end
        end
        rst = 1; en = 0; tick(); rst = 0;
        en = 1; up = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bs !== 4'b0000 || ws !== 1'b0) begin errors++; $display("FAIL sat_dn%0d: got %b/%b expected 0000/0", i, bs, ws); end
        end
        en = 0;
    endtask

    task automatic test_priority();
        load = 1; en = 1; up = 1; lb4 = 4'b0011; tick();
        checks++; if (b4 !== 4'b0011) begin errors++; $display("FAIL prio_load_en: got %b expected 0011", b4); end
        rst = 1; tick(); rst = 0;
        checks++; if (b4 !== 4'b0000 || g4 !== 4'b0000 || w4 !== 1'b0) begin errors++; $display("FAIL prio_rst_load: got %b/%b/%b expected 0", b4, g4, w4); end
        lb4 = 4'b0100; tick(); load = 0; tick();
        checks++; if (b4 !== 4'b0101) begin errors++; $display("FAIL prio_count: got %b expected 0101", b4); end
        rst = 1; tick(); rst = 0; en = 0;
        checks++; if (b4 !== 4'b0000) begin errors++; $display("FAIL prio_rst_mid: got %b expected 0000", b4); end
    endtask

    task automatic test_exhaustive8();
        logic [7:0] prev;
        rst = 1; tick(); rst = 0;
        en = 1;
        for (int d = 0; d < 2; d++) begin
            up = (d == 0);
            for (int i = 0; i < 256; i++) begin
                prev = g8;
                tick();
                checks++; if (popcount(int'(prev ^ g8)) != 1) begin errors++; $display("FAIL ex_onebit: got %h->%h expected one bit change", prev, g8); end
                checks++; if (g8 !== (b8 ^ (b8 >> 1)) || b8 !== m8[7:0]) begin errors++; $display("FAIL ex_value: got %h/%h expected %h/%h", b8, g8, m8[7:0], gray_of(m8)); end
            end
        end
        en = 0;
    endtask

    task automatic test_decoder();
        gv = 1; gi4 = 4'b0100; tick(); gv = 0;
        checks++; if (db4 !== 4'b0111 || dv4 !== 1'b1) begin errors++; $display("FAIL dec_one: got %b/%b expected 0111/1", db4, dv4); end
        tick();
        checks++; if (db4 !== 4'b0111 || dv4 !== 1'b0) begin errors++; $display("FAIL dec_hold: got %b/%b expected 0111/0", db4, dv4); end
    endtask

    task automatic test_back_to_back();
        gv = 1; gi4 = 4'b1000; tick();
        checks++; if (db4 !== 4'b1111 || dv4 !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b/%b expected 1111/1", db4, dv4); end
        gi4 = 4'b1100; tick(); gv = 0;
        checks++; if (db4 !== 4'b1000 || dv4 !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b/%b expected 1000/1", db4, dv4); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1);
            gv   = $urandom_range(0, 1);
            lb4  = 4'($urandom_range(0, 15));
            lb8  = 8'($urandom_range(0, 255));
            gi4  = 4'($urandom_range(0, 15));
            gi8  = 8'($urandom_range(0, 255));
            tick();
            checks++; if (b4 !== m4[3:0] || g4 !== 4'(gray_of(m4)) || w4 !== mw4) begin errors++; $display("FAIL rnd_w4: got %h/%h/%b expected %h/%h/%b", b4, g4, w4, m4, gray_of(m4), mw4); end
            checks++; if (bs !== ms[3:0] || gs !== 4'(gray_of(ms)) || ws !== mws) begin errors++; $display("FAIL rnd_sat: got %h/%h/%b expected %h/%h/%b", bs, gs, ws, ms, gray_of(ms), mws); end
            checks++; if (b8 !== m8[7:0] || g8 !== 8'(gray_of(m8)) || w8 !== mw8) begin errors++; $display("FAIL rnd_w8: got %h/%h/%b expected %h/%h/%b", b8, g8, w8, m8, gray_of(m8), mw8); end
            checks++; if (al4 !== (up ? (m4 == 15) : (m4 == 0)) || al8 !== (up ? (m8 == 255) : (m8 == 0))) begin errors++; $display("FAIL rnd_at_limit: got %b/%b for counts %0d/%0d up=%b", al4, al8, m4, m8, up); end
            checks++; if (db4 !== md4[3:0] || dbs !== md4[3:0] || db8 !== md8[7:0] || dv4 !== mdv || dv8 !== mdv) begin errors++; $display("FAIL rnd_dec: got %h/%h/%b expected %h/%h/%b", db4, db8, dv4, md4, md8, mdv); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_step();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_exhaustive8();
        test_decoder();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
